// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, ACK/NACK bit levels and the
// default 7-bit RTC device address (also used by the i2c_drv instantiation).
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WR,
    ST_WR_ACK,
    ST_RD,
    ST_RD_ACK,
    ST_IGNORE
  } tgt_state_e;

  localparam logic ACK_BIT  = 1'b0;
  localparam logic NACK_BIT = 1'b1;

  localparam logic [6:0] RTC_DEV_ADDR = 7'b101_0001;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchroniser plus history flop for one I2C line.
// Ports: clk, rst_n (sync, active low), line_in (raw pin),
//        level (synchronised level), rise/fall (one-clk edge pulses).
module i2c_line_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], line_in};
    hist_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with 8-bit register pointer and auto-incrementing register-file
// port. Ports: clk, rst_n (sync, active low), scl_in/sda_in (raw pins),
// sda_oe (1 = pull SDA low), reg_addr/reg_rd_data/reg_wr_en/reg_wr_data
// (register-file port), busy (matched transfer in progress).
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEVICE_ADDR = RTC_DEV_ADDR,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  input  logic [7:0] reg_rd_data,
  output logic       reg_wr_en,
  output logic [7:0] reg_wr_data,
  output logic       busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .line_in (scl_in),
    .level   (scl_lvl),
    .rise    (scl_rise),
    .fall    (scl_fall)
  );

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .line_in (sda_in),
    .level   (sda_lvl),
    .rise    (sda_rise),
    .fall    (sda_fall)
  );

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  tgt_state_e  state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        rw_q, rw_d;
  logic        phase_q, phase_d;   // ACK states: driving ACK; RD_ACK: master ACKed
  logic        sda_oe_q, sda_oe_d;
  logic [7:0]  reg_addr_q, reg_addr_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    phase_d    = phase_q;
    sda_oe_d   = sda_oe_q;
    reg_addr_d = reg_addr_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;

    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      phase_d   = 1'b0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      phase_d   = 1'b0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;

        ST_ADDR, ST_PTR, ST_WR: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              phase_d   = 1'b0;
              case (state_q)
                ST_ADDR: begin
                  if (shift_d[7:1] == DEVICE_ADDR) begin
                    state_d = ST_ADDR_ACK;
                    rw_d    = shift_d[0];
                    busy_d  = 1'b1;
                  end else begin
                    state_d = ST_IGNORE;
                  end
                end
                ST_PTR: begin
                  reg_addr_d = shift_d;
                  state_d    = ST_PTR_ACK;
                end
                default: begin
                  wr_en_d   = 1'b1;
                  wr_data_d = shift_d;
                  state_d   = ST_WR_ACK;
                end
              endcase
            end
          end
        end

        // First scl_fall starts the ACK, second one ends it.
        ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              phase_d  = 1'b1;
              sda_oe_d = 1'b1;
              if (state_q == ST_WR_ACK) begin
                reg_addr_d = reg_addr_q + 8'd1;
              end
            end else begin
              phase_d   = 1'b0;
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              if (state_q == ST_ADDR_ACK) begin
                if (rw_q) begin
                  shift_d  = reg_rd_data;
                  sda_oe_d = ~reg_rd_data[7];
                  state_d  = ST_RD;
                end else begin
                  state_d = ST_PTR;
                end
              end else begin
                state_d = ST_WR;
              end
            end
          end
        end

        // shift_q[7] is the bit currently on the bus.
        ST_RD: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              phase_d   = 1'b0;
              state_d   = ST_RD_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end

        ST_RD_ACK: begin
          if (scl_rise && !phase_q) begin
            reg_addr_d = reg_addr_q + 8'd1;
            if (sda_lvl == ACK_BIT) begin
              phase_d = 1'b1;
            end else begin
              state_d = ST_IGNORE;
            end
          end else if (scl_fall && phase_q) begin
            shift_d   = reg_rd_data;
            sda_oe_d  = ~reg_rd_data[7];
            bit_cnt_d = '0;
            phase_d   = 1'b0;
            state_d   = ST_RD;
          end
        end

        ST_IGNORE: begin
          sda_oe_d = 1'b0;
        end

        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rw_q       <= 1'b0;
      phase_q    <= 1'b0;
      sda_oe_q   <= 1'b0;
      reg_addr_q <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      phase_q    <= phase_d;
      sda_oe_q   <= sda_oe_d;
      reg_addr_q <= reg_addr_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
    end
  end

  assign sda_oe      = sda_oe_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_wr_data = wr_data_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
module tb_i2c_target_regs;

  localparam int Q = 10;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_rd_data;
  logic       reg_wr_en;
  logic [7:0] reg_wr_data;
  logic       busy;

  logic [7:0] mem [256];
  logic [7:0] wr_addr_log [16];
  logic [7:0] wr_data_log [16];
  int         wr_n = 0;
  logic       oe_seen = 1'b0;
  logic       busy_seen = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  assign sda_bus     = sda_m & ~sda_oe;
  assign reg_rd_data = mem[reg_addr];

  always #5 clk = ~clk;

  i2c_target_regs #(.DEVICE_ADDR(7'b101_0001), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scl_in      (scl_m),
    .sda_in      (sda_bus),
    .sda_oe      (sda_oe),
    .reg_addr    (reg_addr),
    .reg_rd_data (reg_rd_data),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_data (reg_wr_data),
    .busy        (busy)
  );

  always @(negedge clk) begin
    if (sda_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    if (reg_wr_en) begin
      if (wr_n < 16) begin
        wr_addr_log[wr_n] = reg_addr;
        wr_data_log[wr_n] = reg_wr_data;
      end
      mem[reg_addr] = reg_wr_data;
      wr_n++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_rstart();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    acked = sda_oe;
    tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b1; tick(Q);
      d[i] = sda_bus;
      tick(Q);
      scl_m = 1'b0; tick(Q);
    end
    sda_m = mack; tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(4);
    n_vec++; if (sda_oe !== 1'b0) begin n_bad++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
    n_vec++; if (reg_addr !== 8'h00) begin n_bad++; $display("FAIL reset_reg_addr: got %h want 00", reg_addr); end
    n_vec++; if (reg_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b want 0", reg_wr_en); end
    n_vec++; if (reg_wr_data !== 8'h00) begin n_bad++; $display("FAIL reset_wr_data: got %h want 00", reg_wr_data); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    tick(4);
  endtask

  task automatic test_write();
    logic [7:0] bytes [4];
    logic       ack;
    int         w0;
    bytes[0] = 8'hA2; bytes[1] = 8'h02; bytes[2] = 8'h20; bytes[3] = 8'h15;
    w0 = wr_n;
    bus_start();
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes[i], ack);
      n_vec++; if (ack !== 1'b1) begin n_bad++; $display("FAIL write_ack%0d: got %b want 1", i, ack); end
    end
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL write_busy_mid: got %b want 1", busy); end
    bus_stop();
    tick(Q);
    n_vec++; if (wr_n - w0 != 2) begin n_bad++; $display("FAIL write_count: got %0d want 2", wr_n - w0); end
    n_vec++; if (wr_addr_log[w0] !== 8'h02 || wr_data_log[w0] !== 8'h20)
      begin n_bad++; $display("FAIL write_w0: got %h/%h want 02/20", wr_addr_log[w0], wr_data_log[w0]); end
    n_vec++; if (wr_addr_log[w0+1] !== 8'h03 || wr_data_log[w0+1] !== 8'h15)
      begin n_bad++; $display("FAIL write_w1: got %h/%h want 03/15", wr_addr_log[w0+1], wr_data_log[w0+1]); end
    n_vec++; if (reg_addr !== 8'h04) begin n_bad++; $display("FAIL write_final_addr: got %h want 04", reg_addr); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL write_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_random_read();
    logic       ack;
    logic [7:0] d;
    int         w0;
    mem[8'h05] = 8'h3C;
    mem[8'h06] = 8'h81;
    w0 = wr_n;
    bus_start();
    send_byte(8'hA2, ack);
    send_byte(8'h05, ack);
    bus_rstart();
    send_byte(8'hA3, ack);
    n_vec++; if (ack !== 1'b1) begin n_bad++; $display("FAIL read_addr_ack: got %b want 1", ack); end
    recv_byte(1'b0, d);
    n_vec++; if (d !== 8'h3C) begin n_bad++; $display("FAIL read_byte0: got %h want 3c", d); end
    recv_byte(1'b1, d);
    n_vec++; if (d !== 8'h81) begin n_bad++; $display("FAIL read_byte1: got %h want 81", d); end
    n_vec++; if (sda_oe !== 1'b0) begin n_bad++; $display("FAIL read_oe_after_nack: got %b want 0", sda_oe); end
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL read_busy_after_nack: got %b want 1", busy); end
    bus_stop();
    tick(Q);
    n_vec++; if (reg_addr !== 8'h07) begin n_bad++; $display("FAIL read_final_addr: got %h want 07", reg_addr); end
    n_vec++; if (wr_n != w0) begin n_bad++; $display("FAIL read_no_writes: got %0d want %0d", wr_n, w0); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL read_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_mismatch();
    logic [7:0] bytes [3];
    logic       ack;
    int         w0;
    bytes[0] = 8'hA0; bytes[1] = 8'h02; bytes[2] = 8'h55;
    w0 = wr_n;
    oe_seen = 1'b0;
    busy_seen = 1'b0;
    bus_start();
    for (int i = 0; i < 3; i++) begin
      send_byte(bytes[i], ack);
      n_vec++; if (ack !== 1'b0) begin n_bad++; $display("FAIL mismatch_ack%0d: got %b want 0", i, ack); end
    end
    bus_stop();
    tick(Q);
    n_vec++; if (oe_seen !== 1'b0) begin n_bad++; $display("FAIL mismatch_oe_seen: got %b want 0", oe_seen); end
    n_vec++; if (busy_seen !== 1'b0) begin n_bad++; $display("FAIL mismatch_busy_seen: got %b want 0", busy_seen); end
    n_vec++; if (wr_n != w0) begin n_bad++; $display("FAIL mismatch_no_writes: got %0d want %0d", wr_n, w0); end
    n_vec++; if (reg_addr !== 8'h07) begin n_bad++; $display("FAIL mismatch_addr: got %h want 07", reg_addr); end
  endtask

  task automatic test_wrap();
    logic [7:0] bytes [5];
    logic [7:0] exp_a [3];
    logic [7:0] exp_d [3];
    logic       ack;
    int         w0;
    bytes[0] = 8'hA2; bytes[1] = 8'hFE; bytes[2] = 8'h11; bytes[3] = 8'h22; bytes[4] = 8'h33;
    exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00;
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    w0 = wr_n;
    bus_start();
    for (int i = 0; i < 5; i++) send_byte(bytes[i], ack);
    bus_stop();
    tick(Q);
    n_vec++; if (wr_n - w0 != 3) begin n_bad++; $display("FAIL wrap_count: got %0d want 3", wr_n - w0); end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (wr_addr_log[w0+i] !== exp_a[i] || wr_data_log[w0+i] !== exp_d[i]) begin
        n_bad++;
        $display("FAIL wrap_w%0d: got %h/%h want %h/%h", i, wr_addr_log[w0+i], wr_data_log[w0+i], exp_a[i], exp_d[i]);
      end
    end
    n_vec++; if (reg_addr !== 8'h01) begin n_bad++; $display("FAIL wrap_final_addr: got %h want 01", reg_addr); end
  endtask

  task automatic test_reset_mid_read();
    logic ack;
    int   w0;
    mem[8'h10] = 8'h00;
    bus_start();
    send_byte(8'hA2, ack);
    send_byte(8'h10, ack);
    bus_rstart();
    send_byte(8'hA3, ack);
    n_vec++; if (sda_oe !== 1'b1) begin n_bad++; $display("FAIL rstrd_driving_zero: got %b want 1", sda_oe); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (sda_oe !== 1'b0) begin n_bad++; $display("FAIL rstrd_oe_released: got %b want 0", sda_oe); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstrd_busy: got %b want 0", busy); end
    n_vec++; if (reg_addr !== 8'h00) begin n_bad++; $display("FAIL rstrd_addr: got %h want 00", reg_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    bus_stop();
    tick(Q);
    w0 = wr_n;
    bus_start();
    send_byte(8'hA2, ack);
    n_vec++; if (ack !== 1'b1) begin n_bad++; $display("FAIL rstrd_post_ack: got %b want 1", ack); end
    send_byte(8'h30, ack);
    send_byte(8'h44, ack);
    bus_stop();
    tick(Q);
    n_vec++; if (wr_n - w0 != 1 || wr_addr_log[w0] !== 8'h30 || wr_data_log[w0] !== 8'h44)
      begin n_bad++; $display("FAIL rstrd_post_write: got n=%0d %h/%h want n=1 30/44", wr_n - w0, wr_addr_log[w0], wr_data_log[w0]); end
    n_vec++; if (reg_addr !== 8'h31) begin n_bad++; $display("FAIL rstrd_post_addr: got %h want 31", reg_addr); end
  endtask

  task automatic test_stop_mid_byte();
    logic ack;
    bus_start();
    send_byte(8'hA2, ack);
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL stopmid_busy_mid: got %b want 1", busy); end
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    bus_stop();
    tick(Q);
    n_vec++; if (reg_addr !== 8'h31) begin n_bad++; $display("FAIL stopmid_addr: got %h want 31", reg_addr); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stopmid_busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic ack;
    int   w0;
    w0 = wr_n;
    bus_start();
    send_byte(8'hA2, ack);
    n_vec++; if (ack !== 1'b1) begin n_bad++; $display("FAIL b2b_ack: got %b want 1", ack); end
    send_byte(8'h40, ack);
    send_byte(8'h99, ack);
    bus_stop();
    tick(Q);
    n_vec++; if (wr_n - w0 != 1 || wr_addr_log[w0] !== 8'h40 || wr_data_log[w0] !== 8'h99)
      begin n_bad++; $display("FAIL b2b_write: got n=%0d %h/%h want n=1 40/99", wr_n - w0, wr_addr_log[w0], wr_data_log[w0]); end
    n_vec++; if (reg_addr !== 8'h41) begin n_bad++; $display("FAIL b2b_addr: got %h want 41", reg_addr); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    test_reset();
    test_write();
    test_random_read();
    test_mismatch();
    test_wrap();
    test_reset_mid_read();
    test_stop_mid_byte();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
